// File: rtl/nis_cpu_uart_cpu_mul_pkg.sv
// nis_cpu_uart_cpu_mul_pkg: shared types and constants for the sequenced multiplier.
// Holds the op encoding, the sequencer FSM states, the data widths and the
// accumulator sizing. The accumulator sizing depends on the NIS_CPU_MUL_HIGH_EN macro.
package nis_cpu_uart_cpu_mul_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

`ifdef NIS_CPU_MUL_HIGH_EN
  // Full 64-bit product is needed for the high-word ops.
  localparam int ACC_W = 64;
  localparam logic [1:0] LAST_IDX_HIGH = 2'd3;
`else
  // Only the low word is ever returned, so the upper half is never formed.
  localparam int ACC_W = 32;
  localparam logic [1:0] LAST_IDX_HIGH = 2'd2;
`endif

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSS = 2'b10,
    OP_MULXSU = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_RESP  = 3'd4
  } mul_state_e;

  // Left shift that applies to the partial product issued at a given index.
  function automatic logic [5:0] partial_shift(input logic [1:0] idx);
    logic [5:0] sh;
    case (idx)
      2'd0:    sh = 6'd0;
      2'd3:    sh = 6'd32;
      default: sh = 6'd16;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/nis_cpu_uart_cpu_mul16_reg.sv
// nis_cpu_uart_cpu_mul16_reg: 16x16 unsigned multiplier with a registered product.
// Ports: clk, reset_n (sync clear, active-low), en (load product), a/b (16-bit
// operands), p (32-bit product, valid one cycle after en and held while en=0).
module nis_cpu_uart_cpu_mul16_reg
  import nis_cpu_uart_cpu_mul_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [DATA_W-1:0]   p
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p <= '0;
    end else if (en) begin
      p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/nis_cpu_uart_cpu_mul_seq.sv
// nis_cpu_uart_cpu_mul_seq: 32x32 multiply built from one time-shared 16x16 cell.
// Ports: clk, reset_n (sync, active-low); req_valid/req_ready/req_op/req_src1/
// req_src2 request side; rsp_valid/rsp_ready/rsp_result response side; busy.
// Macro NIS_CPU_MUL_HIGH_EN enables the high-word ops (MULXUU/MULXSS/MULXSU);
// without it those ops run the low-word sequence and return 0.
module nis_cpu_uart_cpu_mul_seq
  import nis_cpu_uart_cpu_mul_pkg::mul_op_e;
  import nis_cpu_uart_cpu_mul_pkg::mul_state_e;
  import nis_cpu_uart_cpu_mul_pkg::OP_MUL;
  import nis_cpu_uart_cpu_mul_pkg::ST_IDLE;
  import nis_cpu_uart_cpu_mul_pkg::ST_ISSUE;
  import nis_cpu_uart_cpu_mul_pkg::ST_DRAIN;
  import nis_cpu_uart_cpu_mul_pkg::ST_FIX;
  import nis_cpu_uart_cpu_mul_pkg::ST_RESP;
  import nis_cpu_uart_cpu_mul_pkg::ACC_W;
  import nis_cpu_uart_cpu_mul_pkg::LAST_IDX_HIGH;
  import nis_cpu_uart_cpu_mul_pkg::partial_shift;
`ifdef NIS_CPU_MUL_HIGH_EN
  import nis_cpu_uart_cpu_mul_pkg::OP_MULXSS;
  import nis_cpu_uart_cpu_mul_pkg::OP_MULXSU;
`endif
#(
  parameter int DATA_W = 32,
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy
);

  // The datapath is hard-wired for a 32-bit word split into two halves.
  if (DATA_W != nis_cpu_uart_cpu_mul_pkg::DATA_W ||
      HALF_W != nis_cpu_uart_cpu_mul_pkg::HALF_W) begin : g_bad_width
    $error("nis_cpu_uart_cpu_mul_seq supports only DATA_W=32, HALF_W=16");
  end

  mul_state_e        state_q;
  mul_op_e           op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        idx_q;
  logic [ACC_W-1:0]  acc_q;
  logic              pvld_q;    // multiplier output holds a partial not yet accumulated
  logic [5:0]        pshift_q;  // shift belonging to that partial

  logic              mul_en;
  logic [HALF_W-1:0] mul_a;
  logic [HALF_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_p;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_sum;
  logic [1:0]        last_idx;

  nis_cpu_uart_cpu_mul16_reg u_mul16 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mul_en),
    .a       (mul_a),
    .b       (mul_b),
    .p       (mul_p)
  );

  // Operand halves for the partial at idx: AL*BL, AL*BH, AH*BL, AH*BH.
  always_comb begin
    mul_en = (state_q == ST_ISSUE);
    mul_a  = a_q[HALF_W-1:0];
    mul_b  = b_q[HALF_W-1:0];
    case (idx_q)
      2'd1: begin
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[DATA_W-1:HALF_W];
      end
      2'd2: begin
        mul_a = a_q[DATA_W-1:HALF_W];
        mul_b = b_q[HALF_W-1:0];
      end
      2'd3: begin
        mul_a = a_q[DATA_W-1:HALF_W];
        mul_b = b_q[DATA_W-1:HALF_W];
      end
      default: begin
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[HALF_W-1:0];
      end
    endcase
  end

  // The low word is complete after AH*BL; only high-word ops need AH*BH.
  always_comb begin
    last_idx = (op_q == OP_MUL) ? 2'd2 : LAST_IDX_HIGH;
  end

  always_comb begin
    addend  = pvld_q ? (ACC_W'(mul_p) << pshift_q) : '0;
    acc_sum = acc_q + addend;
  end

`ifdef NIS_CPU_MUL_HIGH_EN
  // Turn the unsigned high word into a signed one: a negative operand
  // contributes -2^32 * (other operand), i.e. subtract it from the high word.
  logic [DATA_W-1:0] corr;
  logic [DATA_W-1:0] fix_hi;

  always_comb begin
    corr = '0;
    if ((op_q == OP_MULXSS || op_q == OP_MULXSU) && a_q[DATA_W-1]) begin
      corr = corr + b_q;
    end
    if (op_q == OP_MULXSS && b_q[DATA_W-1]) begin
      corr = corr + a_q;
    end
    fix_hi = acc_q[ACC_W-1:DATA_W] - corr;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      pvld_q     <= 1'b0;
      pshift_q   <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else begin
      pvld_q   <= mul_en;
      pshift_q <= partial_shift(idx_q);
      if (pvld_q) begin
        acc_q <= acc_sum;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= mul_op_e'(req_op);
            a_q       <= req_src1;
            b_q       <= req_src2;
            acc_q     <= '0;
            idx_q     <= 2'd0;
            req_ready <= 1'b0;
            state_q   <= ST_ISSUE;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (idx_q == last_idx) begin
            idx_q   <= 2'd0;
            state_q <= ST_DRAIN;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end

        ST_DRAIN: begin
`ifdef NIS_CPU_MUL_HIGH_EN
          if (op_q == OP_MUL) begin
            rsp_result <= acc_sum[DATA_W-1:0];
            rsp_valid  <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            state_q <= ST_FIX;
          end
`else
          // High-word ops are unsupported in this build and return zero.
          rsp_result <= (op_q == OP_MUL) ? acc_sum[DATA_W-1:0] : '0;
          rsp_valid  <= 1'b1;
          state_q    <= ST_RESP;
`endif
        end

        ST_FIX: begin
`ifdef NIS_CPU_MUL_HIGH_EN
          acc_q[ACC_W-1:DATA_W] <= fix_hi;
          rsp_result            <= fix_hi;
          rsp_valid             <= 1'b1;
`endif
          state_q <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nis_cpu_uart_cpu_mul_seq.sv
// tb_nis_cpu_uart_cpu_mul_seq: self-checking bench for the sequenced multiplier.
// Table vectors plus random ops through a result/latency scoreboard, then
// backpressure and mid-operation reset sequences. Follows NIS_CPU_MUL_HIGH_EN.
module tb_nis_cpu_uart_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  always #5 clk = ~clk;

  nis_cpu_uart_cpu_mul_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Full-precision reference products, sign-extended where the op is signed.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00:   p = {32'b0, a} * {32'b0, b};
      2'b01:   p = {32'b0, a} * {32'b0, b};
      2'b10:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: p = {{32{a[31]}}, a} * {32'b0, b};
    endcase
    if (op == 2'b00) return p[31:0];
`ifdef NIS_CPU_MUL_HIGH_EN
    return p[63:32];
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] adj(input logic [1:0] op, input logic [31:0] res);
`ifdef NIS_CPU_MUL_HIGH_EN
    return res;
`else
    return (op == 2'b00) ? res : 32'h0;
`endif
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef NIS_CPU_MUL_HIGH_EN
    return (op == 2'b00) ? 5 : 7;
`else
    return 5;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) chk("req_ready_timeout", {31'b0, req_ready}, 32'h1);
  endtask

  // Drives one request in cycle 0 and returns #1 after the accept edge (cycle 1).
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input bit push);
    exp_t e;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    if (push) begin
      e.res = res;
      e.lat = exp_lat(op);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    // Operand changes after acceptance must not affect the result.
    req_valid = 1'b0;
    req_op    = ~op;
    req_src1  = $urandom;
    req_src2  = $urandom;
  endtask

  // Waits for rsp_valid starting in cycle 1, then pops and checks the scoreboard.
  task automatic collect(input string name);
    int   cyc = 1;
    exp_t e;
    while (rsp_valid !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'h1, 32'h0);
      return;
    end
    e = exp_q.pop_front();
    if (rsp_valid !== 1'b1) begin
      chk({name, "_timeout"}, {31'b0, rsp_valid}, 32'h1);
      return;
    end
    chk({name, "_latency"}, cyc, e.lat);
    chk({name, "_result"}, rsp_result, e.res);
  endtask

  // One op with rsp_ready held high: response lasts one cycle, then idle.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res);
    send(op, a, b, res, 1'b1);
    collect(name);
    @(posedge clk); #1;
    chk({name, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
    chk({name, "_ready_back"}, {31'b0, req_ready}, 32'h1);
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    bit          ok_v;
    bit          ok_r;
    bit          ok_rdy;
    int          seen;

    vecs[0] = '{2'b00, 32'h0001_2345, 32'h0000_6789, 32'h75CC_A2ED};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6] = '{2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[8] = '{2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = '0;
    req_src2  = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            adj(vecs[i].op, vecs[i].res));
    end

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      do_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // Backpressure: response held for 10 cycles, extra request ignored.
    rsp_ready = 1'b0;
    send(2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
         model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
    collect("bp");
    held   = rsp_result;
    ok_v   = 1'b1;
    ok_r   = 1'b1;
    ok_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src1  = 32'd7;
        req_src2  = 32'd9;
      end
      if (i == 4) req_valid = 1'b0;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1) ok_v = 1'b0;
      if (rsp_result !== held) ok_r = 1'b0;
      if (req_ready !== 1'b0) ok_rdy = 1'b0;
    end
    chk("bp_valid_stable", {31'b0, ok_v}, 32'h1);
    chk("bp_result_stable", {31'b0, ok_r}, 32'h1);
    chk("bp_ready_low", {31'b0, ok_rdy}, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'b0, req_ready}, 32'h1);
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 || rsp_valid === 1'b1) seen++;
    end
    chk("bp_pulse_ignored", seen, 32'h0);

    // Reset asserted during ISSUE (cycle 2) abandons the op.
    send(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    chk("midrst_no_rsp", seen, 32'h0);
    do_op("midrst_next", 2'b00, 32'd3, 32'd5, 32'd15);

    chk("sb_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
